mt_reg_file: RTL and testbench
==============================

// Module: mt_reg_file
// PURPOSE
// - Multi-thread register file for the 2-core/4-thread RISC-V core: one bank of DEPTH x DATA_W per hardware thread.
// - Provides two combinational read ports and one write port, with write-to-read forwarding.
// - A per-thread bank-clear FSM zeroes one thread's bank on context switch without a global reset.
// - Sits between the decode/operand-fetch stage (reads) and the writeback stage (writes).
// PARAMETERS
// - DATA_W   64  register width in bits
// - ADDR_W   4   register index width; DEPTH = 2**ADDR_W entries per thread
// - THREADS  4   number of thread banks
// - TID_W    2   thread-id width, clog2(THREADS), minimum 1
// PORTS
// - CLK       in   1       clock; all state updates on posedge
// - RST       in   1       synchronous active-low reset, sampled on posedge CLK
// - wena      in   1       write enable
// - wtid      in   TID_W   write thread id
// - waddr     in   ADDR_W  write register index
// - wdata     in   DATA_W  write data
// - r0tid     in   TID_W   read port 0 thread id
// - r0addr    in   ADDR_W  read port 0 register index
// - r0data    out  DATA_W  read port 0 data (combinational)
// - r1tid     in   TID_W   read port 1 thread id
// - r1addr    in   ADDR_W  read port 1 register index
// - r1data    out  DATA_W  read port 1 data (combinational)
// - clr_req   in   1       request to clear bank clr_tid (single-cycle pulse or level)
// - clr_tid   in   TID_W   thread id to clear, sampled with clr_req in IDLE
// - clr_busy  out  1       clear in progress
// - clr_done  out  1       one-cycle pulse when a clear completes
// - wr_drop   out  1       registered one-cycle pulse: previous-cycle write was discarded
// BEHAVIOUR
// - Reset (RST == 0 at posedge): every entry of every bank = 0; FSM = IDLE; clr_busy = 0; clr_done = 0; wr_drop = 0.
//   Reset overrides any in-flight clear or write.
// - Write: when wena = 1 at a posedge, bank[wtid][waddr] <= wdata. Latency is 1 cycle to the array.
// - Read: rNdata = bank[rNtid][rNaddr], combinational, with the following priority:
//   1) rNtid == busy clear thread while clr_busy = 1 -> 0.
//   2) Forward: wena and a matching (wtid, waddr) and the write is not dropped -> wdata.
//   3) Otherwise -> stored array value.
// - Both read ports are independent. Both may address the same entry at the same time.
// - Clear FSM states:
//   - IDLE: clr_req = 1 -> latch tid, set idx = 0, go to CLEAR, clr_busy = 1 from the next cycle.
//   - CLEAR: each cycle bank[tid][idx] <= 0 and idx++. At idx == DEPTH-1, go to DONE.
//     A clear takes exactly DEPTH cycles in CLEAR.
//   - DONE: clr_done = 1 for one cycle, clr_busy = 0, then IDLE. clr_req is honoured again from IDLE only.
// - clr_req while in CLEAR or DONE is ignored (not queued).
// - A write to the clearing thread while in CLEAR is dropped: no array update, and wr_drop = 1 next cycle.
//   Writes to other threads proceed normally, in the same cycle as clear writes.
// - A write in the same cycle as the IDLE->CLEAR transition to the same thread is also dropped.
// - The idx counter wraps only by returning to IDLE; no partial restart.
// - No X propagation: out-of-range tid (THREADS < 2**TID_W) reads 0, and writes to it are ignored.
// CONFIGURATION
// - ZERO_REG0_EN defined: index 0 of every bank is hardwired to zero.
//   - Writes to index 0 are silently ignored (wr_drop stays 0). Reads of index 0 return 0; no forwarding.
//   - The clear FSM still walks all DEPTH entries, so timing is unchanged.
// - ZERO_REG0_EN undefined: index 0 is an ordinary register.
// TESTING
// - Reset, then write t2/r5 = 64'hDEADBEEF_00000001 -> read t2/r5 gives that value; t1/r5 reads 0.
// - Same-cycle write t0/r3 = 64'h55 with r0 and r1 both reading t0/r3 -> both return 64'h55 in that cycle.
// - Fill t1 with nonzero values, pulse clr_req with tid = 1 -> clr_busy for 16 cycles, clr_done pulses once,
//   all t1 entries read 0, t0/t2/t3 unchanged.
// - During a t1 clear: write t1/r7 -> wr_drop = 1 and t1/r7 = 0 after done; write t3/r7 = 64'h9 -> stored.
// - Assert RST = 0 mid-clear (idx = 6) -> next cycle all banks 0, clr_busy = 0, no clr_done pulse.
// - ZERO_REG0_EN: write t0/r0 = 64'hFF -> read 0, wr_drop = 0. Without the macro -> read 64'hFF.

Source files
------------

// File: rtl/mt_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mt_reg_file : per-thread register banks, two combinational read ports, one
// forwarding write port, and a bank-clear FSM. Optional macro: ZERO_REG0_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mt_reg_file #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4,
  parameter int THREADS = 4,
  parameter int TID_W   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wena,
  input  logic [TID_W-1:0]  wtid,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TID_W-1:0]  r0tid,
  input  logic [ADDR_W-1:0] r0addr,
  output logic [DATA_W-1:0] r0data,
  input  logic [TID_W-1:0]  r1tid,
  input  logic [ADDR_W-1:0] r1addr,
  output logic [DATA_W-1:0] r1data,
  input  logic              clr_req,
  input  logic [TID_W-1:0]  clr_tid,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef ZERO_REG0_EN
  localparam bit ZERO_REG0 = 1'b1;
`else
  localparam bit ZERO_REG0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              clr_start;
  logic [TID_W-1:0]  clr_tid_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [THREADS][DEPTH];

  logic              wtid_ok;
  logic              w_reg0;
  logic              w_conflict;
  logic              w_commit;
  logic              w_drop_now;

  function automatic logic tid_ok(input logic [TID_W-1:0] t);
    return 32'(t) < THREADS;
  endfunction

  always_comb begin
    state_nxt = state;
    clr_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          clr_start = 1'b1;
        end
      end
      ST_CLEAR: if (idx == '1) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = (state == ST_DONE);

  // A write collides with a clear if it targets the bank being walked, or the
  // bank whose clear starts this very cycle.
  assign wtid_ok    = tid_ok(wtid);
  assign w_reg0     = ZERO_REG0 && (waddr == '0);
  assign w_conflict = (clr_busy && (wtid == clr_tid_q)) || (clr_start && (wtid == clr_tid));
  assign w_commit   = wena && wtid_ok && !w_reg0 && !w_conflict;
  assign w_drop_now = wena && wtid_ok && !w_reg0 && w_conflict;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_IDLE;
      clr_tid_q <= '0;
      idx       <= '0;
      wr_drop   <= 1'b0;
      for (int t = 0; t < THREADS; t++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem[t][a] <= '0;
        end
      end
    end else begin
      state   <= state_nxt;
      wr_drop <= w_drop_now;
      if (clr_start) begin
        clr_tid_q <= clr_tid;
        idx       <= '0;
      end else if (clr_busy) begin
        idx <= idx + ADDR_W'(1);
      end
      if (clr_busy && tid_ok(clr_tid_q)) mem[clr_tid_q][idx] <= '0;
      if (w_commit) mem[wtid][waddr] <= wdata;
    end
  end

  logic [TID_W-1:0]  rtid  [2];
  logic [ADDR_W-1:0] raddr [2];
  assign rtid[0]  = r0tid;
  assign rtid[1]  = r1tid;
  assign raddr[0] = r0addr;
  assign raddr[1] = r1addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic              ok;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] val;

    assign ok     = tid_ok(rtid[p]);
    assign stored = ok ? mem[rtid[p]][raddr[p]] : '0;

    always_comb begin
      val = stored;
      if (!ok || (clr_busy && (rtid[p] == clr_tid_q)) || (ZERO_REG0 && (raddr[p] == '0))) begin
        val = '0;
      end else if (w_commit && (rtid[p] == wtid) && (raddr[p] == waddr)) begin
        val = wdata;
      end
    end
  end

  assign r0data = g_rd[0].val;
  assign r1data = g_rd[1].val;

endmodule
`default_nettype wire

// File: tb/tb_mt_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mt_reg_file : scoreboard bench for mt_reg_file; stimulus queues expected
// values, a negedge monitor pops and compares them. Honors ZERO_REG0_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mt_reg_file;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wena = 1'b0;
  logic [1:0]  wtid = '0;
  logic [3:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  r0tid = '0;
  logic [3:0]  r0addr = '0;
  logic [63:0] r0data;
  logic [1:0]  r1tid = '0;
  logic [3:0]  r1addr = '0;
  logic [63:0] r1data;
  logic        clr_req = 1'b0;
  logic [1:0]  clr_tid = '0;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_drop;

`ifdef ZERO_REG0_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  localparam logic [63:0] V_BEEF = 64'hDEADBEEF_00000001;

  mt_reg_file #(.DATA_W(64), .ADDR_W(4), .THREADS(4), .TID_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .wena(wena), .wtid(wtid), .waddr(waddr), .wdata(wdata),
    .r0tid(r0tid), .r0addr(r0addr), .r0data(r0data),
    .r1tid(r1tid), .r1addr(r1addr), .r1data(r1data),
    .clr_req(clr_req), .clr_tid(clr_tid),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  int          q_sel[$];
  logic [63:0] q_exp[$];
  string       q_name[$];

  // sel: 0 r0data, 1 r1data, 2 clr_busy, 3 clr_done, 4 wr_drop
  task automatic expect_v(input int sel, input logic [63:0] v, input string nm);
    q_sel.push_back(sel);
    q_exp.push_back(v);
    q_name.push_back(nm);
  endtask

  always @(negedge CLK) begin
    while (q_sel.size() > 0) begin
      int          s;
      logic [63:0] e;
      logic [63:0] a;
      string       n;
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      case (s)
        0:       a = r0data;
        1:       a = r1data;
        2:       a = {63'b0, clr_busy};
        3:       a = {63'b0, clr_done};
        default: a = {63'b0, wr_drop};
      endcase
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input int max_cyc, input string nm);
    int n;
    n = 0;
    while ((clr_busy !== 1'b1) && (n < max_cyc)) begin
      step();
      n++;
    end
    total++;
    if (clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s: wait for clr_busy expired after %0d cycles", nm, n);
    end
  endtask

  task automatic rd(input logic [1:0] t0, input logic [3:0] a0, input logic [1:0] t1, input logic [3:0] a1);
    r0tid = t0; r0addr = a0; r1tid = t1; r1addr = a1;
  endtask

  task automatic wr(input logic [1:0] t, input logic [3:0] a, input logic [63:0] d);
    wena = 1'b1; wtid = t; waddr = a; wdata = d;
  endtask

  initial begin
    // reset
    step();
    total++;
    if ((clr_busy !== 1'b0) || (clr_done !== 1'b0) || (wr_drop !== 1'b0)) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b drop=%b", clr_busy, clr_done, wr_drop);
    end
    rd(2'd0, 4'd0, 2'd3, 4'd15);
    expect_v(2, 64'd0, "rst_busy");
    expect_v(3, 64'd0, "rst_done");
    expect_v(4, 64'd0, "rst_drop");
    expect_v(0, 64'd0, "rst_r0");
    expect_v(1, 64'd0, "rst_r1");
    step();
    RST = 1'b1;

    // write with forwarding, then stored
    wr(2'd2, 4'd5, V_BEEF);
    rd(2'd2, 4'd5, 2'd1, 4'd5);
    expect_v(0, V_BEEF, "fwd_t2r5");
    expect_v(1, 64'd0, "t1r5_zero");
    step();
    wena = 1'b0;
    expect_v(0, V_BEEF, "stored_t2r5");
    expect_v(1, 64'd0, "t1r5_zero2");
    expect_v(4, 64'd0, "no_drop");
    step();

    // both ports on the entry being written
    wr(2'd0, 4'd3, 64'h55);
    rd(2'd0, 4'd3, 2'd0, 4'd3);
    expect_v(0, 64'h55, "fwd_dual_r0");
    expect_v(1, 64'h55, "fwd_dual_r1");
    step();
    wena = 1'b0;
    expect_v(0, 64'h55, "stored_dual_r0");
    expect_v(1, 64'h55, "stored_dual_r1");
    step();

    // fill t1, plus marker values elsewhere
    for (int i = 0; i < 16; i++) begin
      wr(2'd1, 4'(i), 64'h1000 + 64'(i));
      step();
    end
    wr(2'd0, 4'd1, 64'hA0);
    step();
    wr(2'd3, 4'd2, 64'hB3);
    step();
    wena = 1'b0;
    rd(2'd1, 4'd15, 2'd1, 4'd0);
    expect_v(0, 64'h100F, "t1r15_fill");
    expect_v(1, ZR ? 64'd0 : 64'h1000, "t1r0_fill");
    step();

    // clear request with a same-cycle write to the same thread (dropped)
    clr_req = 1'b1; clr_tid = 2'd1;
    wr(2'd1, 4'd6, 64'hEE);
    rd(2'd1, 4'd6, 2'd1, 4'd4);
    expect_v(0, 64'h1006, "start_nofwd");
    expect_v(1, 64'h1004, "start_read");
    expect_v(2, 64'd0, "start_busy");
    step();

    for (int k = 0; k < 16; k++) begin
      clr_req = 1'b0;
      wena = 1'b0;
      rd(2'd1, 4'd9, 2'd2, 4'd5);
      if (k == 0) expect_v(4, 64'd1, "drop_start");
      if (k == 1) expect_v(4, 64'd0, "drop_clr_k1");
      if (k == 2) wr(2'd1, 4'd7, 64'h77);
      if (k == 3) begin
        expect_v(4, 64'd1, "drop_busy_wr");
        wr(2'd3, 4'd7, 64'h9);
        r1tid = 2'd3; r1addr = 4'd7;
        expect_v(1, 64'h9, "fwd_other_thr");
      end else begin
        expect_v(1, V_BEEF, "t2_during_clr");
      end
      if (k == 4) begin
        expect_v(4, 64'd0, "no_drop_other");
        clr_req = 1'b1; clr_tid = 2'd2;
      end
      expect_v(0, 64'd0, "busy_read_zero");
      expect_v(2, 64'd1, "busy_high");
      expect_v(3, 64'd0, "done_low");
      step();
    end

    clr_req = 1'b0;
    wena = 1'b0;
    expect_v(2, 64'd0, "done_busy_low");
    expect_v(3, 64'd1, "done_pulse");
    step();
    expect_v(2, 64'd0, "idle_busy");
    expect_v(3, 64'd0, "done_once");
    step();
    expect_v(2, 64'd0, "req_ignored");
    step();

    for (int i = 0; i < 8; i++) begin
      rd(2'd1, 4'(i), 2'd1, 4'(i + 8));
      expect_v(0, 64'd0, "t1_cleared_lo");
      expect_v(1, 64'd0, "t1_cleared_hi");
      step();
    end
    rd(2'd0, 4'd3, 2'd0, 4'd1);
    expect_v(0, 64'h55, "t0r3_kept");
    expect_v(1, 64'hA0, "t0r1_kept");
    step();
    rd(2'd2, 4'd5, 2'd3, 4'd2);
    expect_v(0, V_BEEF, "t2r5_kept");
    expect_v(1, 64'hB3, "t3r2_kept");
    step();
    rd(2'd3, 4'd7, 2'd1, 4'd7);
    expect_v(0, 64'h9, "t3r7_stored");
    expect_v(1, 64'd0, "t1r7_dropped");
    step();

    // reset in the middle of a clear of t0
    clr_req = 1'b1; clr_tid = 2'd0;
    step();
    clr_req = 1'b0;
    wait_busy(4, "clr_t0_start");
    for (int k = 0; k < 6; k++) step();
    expect_v(2, 64'd1, "busy_idx6");
    RST = 1'b0;
    step();
    RST = 1'b1;
    rd(2'd3, 4'd7, 2'd2, 4'd5);
    expect_v(2, 64'd0, "midrst_busy");
    expect_v(3, 64'd0, "midrst_done");
    expect_v(0, 64'd0, "midrst_t3r7");
    expect_v(1, 64'd0, "midrst_t2r5");
    step();
    rd(2'd1, 4'd3, 2'd3, 4'd2);
    expect_v(3, 64'd0, "midrst_nodone");
    expect_v(0, 64'd0, "midrst_t1r3");
    expect_v(1, 64'd0, "midrst_t3r2");
    step();

    // index 0 behaviour
    wr(2'd0, 4'd0, 64'hFF);
    rd(2'd0, 4'd0, 2'd0, 4'd0);
    expect_v(0, ZR ? 64'd0 : 64'hFF, "reg0_fwd");
    step();
    wena = 1'b0;
    expect_v(0, ZR ? 64'd0 : 64'hFF, "reg0_read");
    expect_v(4, 64'd0, "reg0_nodrop");
    step();

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
